// File: rtl/grf_wb_pkg.sv
// Shared types and constants for the register-file write-back queue.
package grf_wb_pkg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_req_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/grf_wb_queue_wb_fifo.sv
// Circular buffer for write-back requests. It holds the storage, pointers
// and occupancy count, and exposes the raw entries so the parent can do lookups.
module wb_fifo
  import grf_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wb_req_t       push_req,
  input  logic          pop,
  output wb_req_t       head,
  output wb_req_t       entries [DEPTH],
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;

  // Storage needs no reset; only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/grf_wb_queue.sv
// Write-back queue in front of the register file's single write port.
// Define GRF_WB_TRACE_EN to print a register-file style trace of every commit.
module grf_wb_queue
  import grf_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  output logic        pipe_ready,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic [31:0] pipe_pc,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic [31:0] mdu_pc,
  output logic        grf_we,
  output logic [4:0]  grf_addr,
  output logic [31:0] grf_data,
  output logic [31:0] grf_pc,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_hit1,
  output logic        q_hit2,
  output logic [31:0] q_data1,
  output logic [31:0] q_data2,
  output logic        empty
);

  wb_req_t       req;
  wb_req_t       head;
  wb_req_t       entries [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          accept;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;

  assign pipe_ready = !fifo_full;
  assign mdu_ready  = !fifo_full && !pipe_valid;

  always_comb begin
    req    = '{addr: pipe_addr, data: pipe_data, pc: pipe_pc};
    accept = 1'b0;
    if (pipe_valid && pipe_ready) begin
      accept = 1'b1;
    end else if (mdu_valid && mdu_ready) begin
      req    = '{addr: mdu_addr, data: mdu_data, pc: mdu_pc};
      accept = 1'b1;
    end
  end

  // Writes to $0 are acknowledged but dropped here.
  assign push = accept && (req.addr != REG_ZERO);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_req (req),
    .pop      (!fifo_empty),
    .head     (head),
    .entries  (entries),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we   <= 1'b0;
      grf_addr <= '0;
      grf_data <= '0;
      grf_pc   <= '0;
    end else begin
      grf_we <= !fifo_empty;
      if (!fifo_empty) begin
        grf_addr <= head.addr;
        grf_data <= head.data;
        grf_pc   <= head.pc;
      end
    end
  end

  // Scan oldest to youngest so the last match wins; the grf stage is older than any entry.
  function automatic logic [32:0] lookup(input logic [4:0] a);
    logic [32:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    if (a != REG_ZERO) begin
      if (grf_we && grf_addr == a) r = {1'b1, grf_data};
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PW'(k);
        if (CW'(k) < count && entries[idx].addr == a) r = {1'b1, entries[idx].data};
      end
    end
    return r;
  endfunction

  assign {q_hit1, q_data1} = lookup(q_addr1);
  assign {q_hit2, q_data2} = lookup(q_addr2);

  assign empty = fifo_empty && !grf_we;

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (reset && grf_we) $display("@%08h: $%02d <= %08h", grf_pc, grf_addr, grf_data);
  end
`endif

endmodule

// File: tb/tb_grf_wb_queue.sv
// Randomized and directed bench for grf_wb_queue against a queue-based model.
module tb_grf_wb_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, mdu_valid;
  logic        pipe_ready, mdu_ready;
  logic [4:0]  pipe_addr, mdu_addr;
  logic [31:0] pipe_data, pipe_pc, mdu_data, mdu_pc;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data, grf_pc;
  logic [4:0]  q_addr1, q_addr2;
  logic        q_hit1, q_hit2;
  logic [31:0] q_data1, q_data2;
  logic        empty;

  int total = 0;
  int bad   = 0;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_pc;

  always #5 clk = ~clk;

  grf_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready),
    .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_pc(mdu_pc),
    .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data), .grf_pc(grf_pc),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .q_data1(q_data1), .q_data2(q_data2),
    .empty(empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_lookup(input logic [4:0] a);
    if (a == 5'd0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].addr == a) return {1'b1, mq[i].data};
    if (m_we && m_addr == a) return {1'b1, m_data};
    return '0;
  endfunction

  task automatic check_all();
    logic [32:0] l1, l2;
    logic        pr;
    pr = (mq.size() < DEPTH);
    l1 = model_lookup(q_addr1);
    l2 = model_lookup(q_addr2);
    chk("pipe_ready", 32'(pipe_ready), 32'(pr));
    chk("mdu_ready",  32'(mdu_ready),  32'(pr && !pipe_valid));
    chk("grf_we",     32'(grf_we),     32'(m_we));
    chk("grf_addr",   32'(grf_addr),   32'(m_addr));
    chk("grf_data",   grf_data,        m_data);
    chk("grf_pc",     grf_pc,          m_pc);
    chk("empty",      32'(empty),      32'(mq.size() == 0 && !m_we));
    chk("q_hit1",     32'(q_hit1),     32'(l1[32]));
    chk("q_data1",    q_data1,         l1[31:0]);
    chk("q_hit2",     32'(q_hit2),     32'(l2[32]));
    chk("q_data2",    q_data2,         l2[31:0]);
  endtask

  // Effect of the coming rising edge on the model: pop the oldest, then accept one request.
  task automatic model_step();
    logic pr;
    ent_t e;
    pr = (mq.size() < DEPTH);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_addr = e.addr; m_data = e.data; m_pc = e.pc;
    end else begin
      m_we = 1'b0;
    end
    if (pipe_valid && pr) begin
      if (pipe_addr != 5'd0) mq.push_back('{pipe_addr, pipe_data, pipe_pc});
    end else if (mdu_valid && pr) begin
      if (mdu_addr != 5'd0) mq.push_back('{mdu_addr, mdu_data, mdu_pc});
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0; m_pc = '0;
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    #1;
    if (!reset) model_clear();
    check_all();
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pipe_valid = 0; mdu_valid = 0;
    pipe_addr = 0; pipe_data = 0; pipe_pc = 0;
    mdu_addr = 0; mdu_data = 0; mdu_pc = 0;
  endtask

  task automatic pipe_req(input logic [4:0] a, input logic [31:0] d);
    pipe_valid = 1; pipe_addr = a; pipe_data = d; pipe_pc = 32'h1000 + 32'(a) * 4;
  endtask

  initial begin
    model_clear();
    idle_inputs();
    q_addr1 = 0; q_addr2 = 0;
    reset = 0;
    @(negedge clk);

    // Requests during reset are ignored.
    pipe_req(5, 32'h55);
    tick(); tick();
    chk("lit_rst_we", 32'(grf_we), 32'd0);
    chk("lit_rst_empty", 32'(empty), 32'd1);
    chk("lit_rst_pipe_ready", 32'(pipe_ready), 32'd1);

    reset = 1;
    pipe_req(5, 32'h1234);
    q_addr2 = 5;
    tick();
    idle_inputs();
    #1 chk("lit_lat_we_n", 32'(grf_we), 32'd0);
    chk("lit_lat_hit_queued", 32'(q_hit2), 32'd1);
    tick();
    chk("lit_lat_we", 32'(grf_we), 32'd1);
    chk("lit_lat_addr", 32'(grf_addr), 32'd5);
    chk("lit_lat_data", grf_data, 32'h1234);
    tick();

    // Pipeline has priority over the MDU.
    pipe_req(3, 32'h33);
    mdu_valid = 1; mdu_addr = 4; mdu_data = 32'h44; mdu_pc = 32'h2000;
    #1 chk("lit_prio_mdu_ready", 32'(mdu_ready), 32'd0);
    tick();
    pipe_valid = 0;
    #1 chk("lit_prio_mdu_retry", 32'(mdu_ready), 32'd1);
    tick();
    mdu_valid = 0;
    chk("lit_prio_first", 32'(grf_addr), 32'd3);
    tick();
    chk("lit_prio_second", 32'(grf_addr), 32'd4);
    chk("lit_prio_second_data", grf_data, 32'h44);
    tick();

    // Back-to-back burst drains in order.
    for (int i = 0; i < 6; i++) begin
      pipe_req(5'(10 + i), 32'(100 + i));
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();

    // Two pending writes to $7: youngest data wins.
    q_addr1 = 7;
    pipe_req(7, 32'hA); tick();
    pipe_req(7, 32'hB); tick();
    idle_inputs();
    #1 chk("lit_fwd_both", q_data1, 32'hB);
    chk("lit_fwd_hit", 32'(q_hit1), 32'd1);
    tick();
    chk("lit_fwd_one", q_data1, 32'hB);
    tick();
    chk("lit_fwd_gone", 32'(q_hit1), 32'd0);

    // Writes to $0 are swallowed.
    pipe_req(0, 32'hFFFF);
    q_addr1 = 0;
    #1 chk("lit_zero_ready", 32'(pipe_ready), 32'd1);
    tick();
    idle_inputs();
    tick();
    chk("lit_zero_we", 32'(grf_we), 32'd0);
    chk("lit_zero_hit", 32'(q_hit1), 32'd0);
    tick();

    // Reset with writes in flight discards them.
    for (int i = 0; i < 3; i++) begin
      pipe_req(5'(20 + i), 32'(200 + i));
      tick();
    end
    idle_inputs();
    reset = 0;
    tick();
    chk("lit_midrst_we", 32'(grf_we), 32'd0);
    chk("lit_midrst_empty", 32'(empty), 32'd1);
    reset = 1;
    tick(); tick(); tick();

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 99) != 0);
      pipe_valid = ($urandom_range(0, 99) < 45);
      mdu_valid  = ($urandom_range(0, 99) < 45);
      pipe_addr  = 5'($urandom_range(0, 7));
      mdu_addr   = 5'($urandom_range(0, 7));
      pipe_data  = $urandom; pipe_pc = $urandom;
      mdu_data   = $urandom; mdu_pc  = $urandom;
      q_addr1    = 5'($urandom_range(0, 7));
      q_addr2    = 5'($urandom_range(0, 7));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
